uart_tx_ser_par: RTL and testbench
==================================

Name: uart_tx_ser_par

Overview:
UART transmit datapath that sits directly downstream of the TX control FSM.
- Captures the parallel byte when a new frame is accepted.
- Serializes the byte LSB-first under the FSM's ser_en strobe and reports ser_done.
- Computes the parity bit.
- Drives the TX line through the 4-way frame mux selected by the FSM's mux_sel.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal range 5..9); bit counter width is clog2(DATA_WIDTH+1).

Ports:
Clk  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
P_DATA  input  DATA_WIDTH  parallel payload
Data_Valid  input  1  payload valid strobe from upstream
busy  input  1  FSM frame-in-progress flag
ser_en  input  1  FSM shift enable
mux_sel  input  2  FSM frame-field select
PAR_TYP  input  1  0 = even parity, 1 = odd parity
ser_done  output  1  all payload bits presented
TX_OUT  output  1  serial line

Behaviour:
- Reset: RST high at a rising Clk edge clears the shift register, the bit counter, ser_data_q and par_bit_q to 0.
- Reset: while RST is high, TX_OUT is forced to 1 (line idle) regardless of mux_sel.
- Reset mid-frame: the frame is aborted with no residual shifting; ser_done reads 0 after reset.
- Load: when Data_Valid=1 and busy=0 at an edge:
  - shift_reg <= P_DATA
  - cnt <= 0
  - par_bit_q <= ^P_DATA XOR PAR_TYP (PAR_TYP is sampled only here)
- Data_Valid while busy=1 is ignored: no reload and no corruption of the frame in flight.
- Shift: when ser_en=1 and cnt < DATA_WIDTH at an edge:
  - ser_data_q <= shift_reg[0]
  - shift_reg <= shift_reg >> 1
  - cnt <= cnt + 1
- ser_en=1 with cnt == DATA_WIDTH: no shift; cnt saturates.
- Load and shift in the same cycle: load wins. This cannot occur with the FSM, because ser_en=0 while busy=0.
- ser_done = (cnt == DATA_WIDTH), combinational. It stays high until the next load.
- Timing against the FSM:
  - The start-state ser_en pulse pre-fetches bit0 into ser_data_q.
  - Data cycle k (1..DATA_WIDTH) presents bit k-1.
  - ser_done is high during data cycle DATA_WIDTH, so the FSM leaves the data state after exactly DATA_WIDTH data cycles.
- TX_OUT (combinational from mux_sel when RST=0):
  - 00 -> 0 (start bit)
  - 01 -> 1 (stop/idle)
  - 10 -> ser_data_q
  - 11 -> par_bit_q
- Latency: Data_Valid edge to start bit on TX_OUT = 1 cycle, i.e. the FSM start-state cycle.
- Back-to-back frames: a load in the same edge that ends the stop cycle is legal and fully resets cnt and ser_done.

Optional Feature:
UART_TX_MSB_FIRST_EN
- Defined: serialization is MSB-first.
  - Shift presents shift_reg[DATA_WIDTH-1] and shifts left.
  - Parity, counter, ser_done and timing are unchanged.
- Undefined: LSB-first as above.

Test Plan:
- P_DATA=0xA5, PAR_TYP=0, PAR_EN=1 in FSM, DATA_WIDTH=8 -> TX_OUT sequence:
  - 0 (start)
  - 1,0,1,0,0,1,0,1 (data)
  - 0 (parity)
  - 1 (stop)
  - ser_done high only in the 8th data cycle.
- Same byte, PAR_TYP=1 -> parity bit 1; all other bits identical.
- P_DATA=0x3C with parity disabled in FSM -> 0,0,0,1,1,1,1,0,0,1; par_bit_q unused.
- Data_Valid with P_DATA=0xFF asserted at data cycle 3 of a 0x00 frame -> frame continues as all-zero data; 0xFF is not captured.
- RST pulsed at data cycle 4 -> TX_OUT=1 during reset; cnt=0, ser_done=0 after reset; the next Data_Valid with 0x81 produces a clean frame.
- With UART_TX_MSB_FIRST_EN and P_DATA=0xA5 -> data bits 1,0,1,0,0,1,0,1 MSB-first; parity unchanged.

Source files
------------

// File: rtl/uart_tx_ser_par.sv
// UART TX datapath: byte capture, bit serializer, parity generator and 4-way frame mux.
// Optional macro UART_TX_MSB_FIRST_EN selects MSB-first serialization (default LSB-first).
module uart_tx_ser_par #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  busy,
   input  logic                  ser_en,
   input  logic [1:0]            mux_sel,
   input  logic                  PAR_TYP,
   output logic                  ser_done,
   output logic                  TX_OUT
);

   localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  ser_data_q, ser_data_d;
   logic                  par_bit_q, par_bit_d;

   // Load has priority over shift; the FSM never asserts ser_en while idle anyway.
   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      ser_data_d = ser_data_q;
      par_bit_d  = par_bit_q;
      if (Data_Valid && !busy) begin
         shift_d   = P_DATA;
         cnt_d     = '0;
         par_bit_d = (^P_DATA) ^ PAR_TYP;
      end else if (ser_en && (cnt_q < CntMax)) begin
`ifdef UART_TX_MSB_FIRST_EN
         ser_data_d = shift_q[DATA_WIDTH-1];
         shift_d    = {shift_q[DATA_WIDTH-2:0], 1'b0};
`else
         ser_data_d = shift_q[0];
         shift_d    = {1'b0, shift_q[DATA_WIDTH-1:1]};
`endif
         cnt_d      = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (RST) begin
         shift_q    <= '0;
         cnt_q      <= '0;
         ser_data_q <= 1'b0;
         par_bit_q  <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         ser_data_q <= ser_data_d;
         par_bit_q  <= par_bit_d;
      end
   end

   assign ser_done = (cnt_q == CntMax);

   // Line is held idle-high for the whole reset, whatever the FSM selects.
   always_comb begin
      TX_OUT = 1'b1;
      if (!RST) begin
         unique case (mux_sel)
            2'b00: TX_OUT = 1'b0;
            2'b01: TX_OUT = 1'b1;
            2'b10: TX_OUT = ser_data_q;
            2'b11: TX_OUT = par_bit_q;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ser_par.sv
// Directed bench for uart_tx_ser_par: models the TX FSM handshake and checks line bit sequences.
module tb_uart_tx_ser_par;

   logic       Clk;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       busy;
   logic       ser_en;
   logic [1:0] mux_sel;
   logic       PAR_TYP;
   logic       ser_done;
   logic       TX_OUT;

   int n_cmp;
   int n_fail;

   uart_tx_ser_par #(.DATA_WIDTH(8)) dut (
      .Clk        (Clk),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .busy       (busy),
      .ser_en     (ser_en),
      .mux_sel    (mux_sel),
      .PAR_TYP    (PAR_TYP),
      .ser_done   (ser_done),
      .TX_OUT     (TX_OUT)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One frame as the FSM would run it; returns line bits and ser_done per cycle.
   // Leaves time at the negedge of the stop cycle so a following load ends that cycle.
   task automatic drive_frame(input logic [7:0] data, input logic ptyp, input logic pen,
                              input int inject_cyc, output logic [0:10] tx,
                              output logic [0:10] done, output int n);
      tx = '0;
      done = '0;
      n = 0;
      Data_Valid = 1'b1;
      P_DATA = data;
      PAR_TYP = ptyp;
      busy = 1'b0;
      ser_en = 1'b0;
      mux_sel = 2'b01;
      tick();
      Data_Valid = 1'b0;
      P_DATA = 8'h00;
      PAR_TYP = ~ptyp;
      busy = 1'b1;
      ser_en = 1'b1;
      mux_sel = 2'b00;
      @(negedge Clk);
      tx[n] = TX_OUT;
      done[n] = ser_done;
      n++;
      tick();
      for (int k = 1; k <= 8; k++) begin
         mux_sel = 2'b10;
         ser_en = 1'b1;
         Data_Valid = (k == inject_cyc);
         P_DATA = (k == inject_cyc) ? 8'hFF : 8'h00;
         @(negedge Clk);
         tx[n] = TX_OUT;
         done[n] = ser_done;
         n++;
         tick();
      end
      Data_Valid = 1'b0;
      P_DATA = 8'h00;
      ser_en = 1'b0;
      if (pen) begin
         mux_sel = 2'b11;
         @(negedge Clk);
         tx[n] = TX_OUT;
         done[n] = ser_done;
         n++;
         tick();
      end
      mux_sel = 2'b01;
      busy = 1'b0;
      @(negedge Clk);
      tx[n] = TX_OUT;
      done[n] = ser_done;
      n++;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      mux_sel = 2'b00;
      tick();
      tick();
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tx_mux00: got %b want 1", TX_OUT);
      end
      mux_sel = 2'b10;
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tx_mux10: got %b want 1", TX_OUT);
      end
      RST = 1'b0;
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ser_data: got %b want 0", TX_OUT);
      end
      n_cmp++;
      if (ser_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ser_done: got %b want 0", ser_done);
      end
      mux_sel = 2'b11;
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_par_bit: got %b want 0", TX_OUT);
      end
      mux_sel = 2'b00;
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL mux_start: got %b want 0", TX_OUT);
      end
      mux_sel = 2'b01;
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b1) begin
         n_fail++;
         $display("FAIL mux_stop: got %b want 1", TX_OUT);
      end
      tick();
   endtask

   task automatic test_even_parity();
      logic [0:10] tx, done;
      logic [0:10] exp_tx, exp_done;
      int n;
      exp_tx = 11'b0_10100101_0_1;
      exp_done = 11'b0_00000001_1_1;
      drive_frame(8'hA5, 1'b0, 1'b1, 0, tx, done, n);
      tick();
      n_cmp++;
      if (n !== 11) begin
         n_fail++;
         $display("FAIL even_len: got %0d want 11", n);
      end
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL even_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
         n_cmp++;
         if (done[i] !== exp_done[i]) begin
            n_fail++;
            $display("FAIL even_done[%0d]: got %b want %b", i, done[i], exp_done[i]);
         end
      end
   endtask

   task automatic test_odd_parity();
      logic [0:10] tx, done;
      logic [0:10] exp_tx;
      int n;
      exp_tx = 11'b0_10100101_1_1;
      drive_frame(8'hA5, 1'b1, 1'b1, 0, tx, done, n);
      tick();
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL odd_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
      end
   endtask

   task automatic test_no_parity();
      logic [0:10] tx, done;
      logic [0:9] exp_tx, exp_done;
      int n;
      exp_tx = 10'b0_00111100_1;
      exp_done = 10'b0_00000001_1;
      drive_frame(8'h3C, 1'b0, 1'b0, 0, tx, done, n);
      tick();
      n_cmp++;
      if (n !== 10) begin
         n_fail++;
         $display("FAIL nopar_len: got %0d want 10", n);
      end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL nopar_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
         n_cmp++;
         if (done[i] !== exp_done[i]) begin
            n_fail++;
            $display("FAIL nopar_done[%0d]: got %b want %b", i, done[i], exp_done[i]);
         end
      end
   endtask

   // Asymmetric byte so bit order is visible on the line.
   task automatic test_bit_order();
      logic [0:10] tx, done;
      logic [0:10] exp_tx;
      int n;
`ifdef UART_TX_MSB_FIRST_EN
      exp_tx = 11'b0_00001111_0_1;
`else
      exp_tx = 11'b0_11110000_0_1;
`endif
      drive_frame(8'h0F, 1'b0, 1'b1, 0, tx, done, n);
      tick();
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL order_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [0:10] tx, done;
      logic [0:10] exp_tx, exp_done;
      int n;
      exp_tx = 11'b0_00000000_1_1;
      exp_done = 11'b0_00000001_1_1;
      drive_frame(8'h00, 1'b1, 1'b1, 3, tx, done, n);
      tick();
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL busy_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
         n_cmp++;
         if (done[i] !== exp_done[i]) begin
            n_fail++;
            $display("FAIL busy_done[%0d]: got %b want %b", i, done[i], exp_done[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [0:10] tx, done;
      logic [0:10] exp_tx, exp_done;
      int n;
`ifdef UART_TX_MSB_FIRST_EN
      exp_tx = 11'b0_00001111_1_1;
`else
      exp_tx = 11'b0_11110000_1_1;
`endif
      exp_done = 11'b0_00000001_1_1;
      drive_frame(8'hA5, 1'b0, 1'b1, 0, tx, done, n);
      // Second load lands on the edge that ends the first frame's stop cycle.
      drive_frame(8'h0F, 1'b1, 1'b1, 0, tx, done, n);
      tick();
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL b2b_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
         n_cmp++;
         if (done[i] !== exp_done[i]) begin
            n_fail++;
            $display("FAIL b2b_done[%0d]: got %b want %b", i, done[i], exp_done[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [0:10] tx, done;
      logic [0:10] exp_tx;
      int n;
      exp_tx = 11'b0_10000001_0_1;
      Data_Valid = 1'b1;
      P_DATA = 8'h00;
      PAR_TYP = 1'b0;
      busy = 1'b0;
      ser_en = 1'b0;
      mux_sel = 2'b01;
      tick();
      Data_Valid = 1'b0;
      busy = 1'b1;
      ser_en = 1'b1;
      mux_sel = 2'b00;
      tick();
      mux_sel = 2'b10;
      repeat (3) tick();
      RST = 1'b1;
      #1;
      n_cmp++;
      if (TX_OUT !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_tx: got %b want 1", TX_OUT);
      end
      tick();
      RST = 1'b0;
      busy = 1'b0;
      ser_en = 1'b0;
      #1;
      n_cmp++;
      if (ser_done !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_done: got %b want 0", ser_done);
      end
      n_cmp++;
      if (TX_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_ser_data: got %b want 0", TX_OUT);
      end
      mux_sel = 2'b01;
      tick();
      drive_frame(8'h81, 1'b0, 1'b1, 0, tx, done, n);
      tick();
      for (int i = 0; i < 11; i++) begin
         n_cmp++;
         if (tx[i] !== exp_tx[i]) begin
            n_fail++;
            $display("FAIL midrst_next_tx[%0d]: got %b want %b", i, tx[i], exp_tx[i]);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      RST = 1'b1;
      P_DATA = 8'h00;
      Data_Valid = 1'b0;
      busy = 1'b0;
      ser_en = 1'b0;
      mux_sel = 2'b01;
      PAR_TYP = 1'b0;
      test_reset();
      test_even_parity();
      test_odd_parity();
      test_no_parity();
      test_bit_order();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
